stream_frame_fifo: RTL
======================

Name: stream_frame_fifo

Overview:
Frame-aware Avalon-ST FIFO placed directly downstream of filter_select, feeding the video scaler sink of the VGA interface. It carries pixel data with sop/eop, converts the scaler's ready backpressure into a proper valid/ready handshake, and absorbs short stalls. After reset it aligns to frame boundaries, so the scaler never receives a partial first frame.

Parameters:
DATA_W, 12, pixel width (RGB444)
DEPTH, 16, FIFO entries; power of two, >= 2
FRAME_PIXELS, 76800, expected beats per frame, sop to eop inclusive (320x240); used only by the optional check

Ports:
clk  in  1  system clock (clk_50 domain)
reset  in  1  asynchronous, active-high reset
data_in  in  DATA_W  pixel from filter stage
sop_in  in  1  start of packet
eop_in  in  1  end of packet
valid_in  in  1  upstream beat valid
ready_out  out  1  backpressure to upstream
data_out  out  DATA_W  pixel to scaler sink
sop_out  out  1  start of packet, head entry
eop_out  out  1  end of packet, head entry
valid_out  out  1  head entry valid
ready_in  in  1  scaler sink ready
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
frame_err  out  1  one-cycle frame-error pulse (optional feature)

Behaviour:
- Reset (async, active-high):
  - Clears pointers; level=0.
  - State=HUNT.
  - Outputs: valid_out=0, data_out=0, sop_out=0, eop_out=0, frame_err=0, ready_out=1.
  - Asserting reset mid-frame flushes all stored beats immediately.
- Storage: DEPTH entries of {sop, eop, data} (DATA_W+2 bits). Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Input accept condition: accept = valid_in && ready_out.
- Write rule: write = accept && (state==PASS || sop_in).
- State machine:
  - HUNT: ready_out=1. Accepted beats with sop_in=0 are discarded (not written). A beat accepted with sop_in=1 is written, and the state becomes PASS on that edge.
  - PASS: ready_out = (level != DEPTH). Every accepted beat is written. The state stays PASS until reset.
- Output, first-word-fall-through:
  - valid_out = (level != 0).
  - {sop_out, eop_out, data_out} show the head entry from registered storage.
  - All three are forced to 0 when level==0.
- Read rule: read = valid_out && ready_in. The read pointer advances on that edge.
- Latency: a beat written at edge N appears on valid_out after edge N if the FIFO was empty (1 cycle).
- Level update:
  - write only: level+1.
  - read only: level-1.
  - simultaneous write and read: level unchanged.
- Boundary conditions:
  - Full: ready_out=0, so no write occurs. A read in the same cycle frees a slot; ready_out rises the following cycle (no combinational ready_in->ready_out path).
  - Empty: no read occurs, even if ready_in=1.
  - Pointer wrap-around preserves strict FIFO order.
- Data is never modified. Beat order and sop/eop flags are preserved exactly.

Optional Feature:
Macro: STREAM_FIFO_FRAME_CHECK_EN
- Defined:
  - A pixel counter (width $clog2(FRAME_PIXELS)+1) runs on written beats.
  - A written sop beat loads the counter to 1. Each subsequent written beat increments it.
  - frame_err pulses high for exactly one cycle, the cycle after the offending write, when either:
    - a written eop has count != FRAME_PIXELS, or
    - a written sop arrives while a frame is open (no eop since the last sop).
  - Reset clears the counter and the open-frame flag.
  - Beats are still passed through unchanged.
- Undefined: frame_err tied 0; no counter logic is synthesized.

Test Plan:
- Fill to full: after reset, sop plus 19 beats with valid_in=1 and ready_in=0 -> 16 beats stored (DEPTH=16), level=16, ready_out=0 from the cycle after the 16th write, and the upstream holds the remaining beats.
- Hunt discard: after reset, 5 beats with sop=0 (data 0x001..0x005), then a sop beat 0xABC -> level stays 0 through the first 5 beats; the first output beat is 0xABC with sop_out=1.
- Steady streaming: level at 8, then 10 cycles with valid_in=1 and ready_in=1 -> level stays 8 each cycle; output order equals input order, including across pointer wrap.
- Full drain and refill: full, then ready_in=1 for one cycle -> level=15, and ready_out=1 the next cycle; one new write brings level back to 16.
- Reset mid-frame: reset asserted at level=10 -> immediately valid_out=0 and level=0; after release, the FIFO is back in HUNT and non-sop beats are dropped.
- Frame check (macro defined, FRAME_PIXELS=8): sop plus 5 beats with eop on the 6th -> frame_err=1 for exactly one cycle; a clean 8-beat frame -> frame_err stays 0.

Source files
------------

// File: rtl/stream_frame_fifo.sv
// Frame-aware Avalon-ST FIFO: first-word-fall-through, drops beats until the first sop after reset.
// Optional frame length/nesting check enabled by defining STREAM_FIFO_FRAME_CHECK_EN.
module stream_frame_fifo #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     sop_in,
  input  logic                     eop_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [DATA_W-1:0]        data_out,
  output logic                     sop_out,
  output logic                     eop_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic                     state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] S_HUNT = 1'b0;
  localparam logic [0:0] S_PASS = 1'b1;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // valid never depends on ready, and ready_out is a function of registered state only.
  logic [0:0]        r_state;
  logic [DATA_W+1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_full;
  logic              w_accept;
  logic              w_write;
  logic              w_read;
  logic [DATA_W+1:0] w_head;

  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign ready_out = (r_state == S_HUNT) || !w_full;
  assign w_accept  = valid_in && ready_out;
  assign w_write   = w_accept && ((r_state == S_PASS) || sop_in);
  assign valid_out = (r_level != '0);
  assign w_read    = valid_out && ready_in;
  assign w_head    = r_mem[r_rd_ptr];
  assign sop_out   = valid_out && w_head[DATA_W+1];
  assign eop_out   = valid_out && w_head[DATA_W];
  assign data_out  = valid_out ? w_head[DATA_W-1:0] : '0;
  assign level     = r_level;
  assign state_dbg = r_state;

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {sop_in, eop_in, data_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_HUNT;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept && sop_in) r_state <= S_PASS;
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_read})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef STREAM_FIFO_FRAME_CHECK_EN
  localparam int CW = $clog2(FRAME_PIXELS) + 1;

  logic [CW-1:0] r_pix_cnt;
  logic [CW-1:0] w_beat_cnt;
  logic          r_frame_open;
  logic          r_frame_err;
  logic          w_err;

  // w_beat_cnt is the position of the beat being written, counting sop as 1.
  always_comb begin
    w_beat_cnt = sop_in ? CW'(1) : r_pix_cnt + CW'(1);
    w_err      = w_write && ((sop_in && r_frame_open) ||
                             (eop_in && (w_beat_cnt != CW'(FRAME_PIXELS))));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_cnt    <= '0;
      r_frame_open <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_write) begin
        r_pix_cnt <= w_beat_cnt;
        if (eop_in)      r_frame_open <= 1'b0;
        else if (sop_in) r_frame_open <= 1'b1;
      end
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule
